alu_muldiv_seq: RTL and testbench

Multi-cycle sequencer that runs 8×8 unsigned multiply and 16÷8 unsigned divide on the shared 65C02 ALU by issuing one ALU operation per cycle. It sits beside the CPU core as a coprocessor: it owns the ALU control/operand inputs while busy and consumes the ALU's registered OUT/CO. The ALU's BCD input is tied off, and its RDY input follows this block's stall input.

---
 rtl/alu_muldiv_seq.sv | 210 +++++++++++++++++++++
 tb/tb_alu_muldiv_seq.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/alu_muldiv_seq.sv
// Multiply/divide sequencer that drives the shared 65C02 ALU one op per cycle.
module alu_muldiv_seq (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        rdy,
  input  logic        start,
  input  logic        div,
  input  logic [15:0] a,
  input  logic [7:0]  b,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [7:0]  result_hi,
  output logic [7:0]  result_lo,
  output logic [3:0]  alu_op,
  output logic        alu_right,
  output logic [7:0]  alu_ai,
  output logic [7:0]  alu_bi,
  output logic        alu_ci,
  output logic        alu_bcd,
  output logic        alu_rdy,
  input  logic [7:0]  alu_out,
  input  logic        alu_co
);

  localparam int unsigned DW = 8;
  localparam int unsigned CW = 3;

  localparam logic [3:0] OP_ADD  = 4'b0011;
  localparam logic [3:0] OP_SUB  = 4'b0111;
  localparam logic [3:0] OP_ROL  = 4'b1011;
  localparam logic [3:0] OP_PASS = 4'b1111;

  typedef enum logic [2:0] {
    S_IDLE, S_MUL_ADD, S_MUL_ROR, S_DIV_CHK, S_DIV_SHL, S_DIV_SUB, S_FIN
  } state_t;

  state_t          r_state, w_state_nxt;
  logic [DW-1:0]   r_q, r_d, r_r, r_rs, r_hi, r_lo;
  logic [CW-1:0]   r_cnt;
  logic            r_first, r_c9, r_div, r_busy, r_done, r_err;

  logic [DW-1:0]   w_q_nxt, w_d_nxt, w_r_nxt, w_rs_nxt, w_hi_nxt, w_lo_nxt;
  logic [CW-1:0]   w_cnt_nxt;
  logic            w_first_nxt, w_c9_nxt, w_div_nxt, w_busy_nxt, w_done_nxt, w_err_nxt;
  logic [3:0]      w_alu_op;
  logic            w_alu_right, w_alu_ci;
  logic [DW-1:0]   w_alu_ai, w_alu_bi;
  logic            w_qb;
  logic [DW-1:0]   w_rc;

  // Quotient bit: 9-bit partial remainder overflowed or subtract did not borrow
  assign w_qb = r_c9 | alu_co;
  assign w_rc = r_first ? r_r : (w_qb ? alu_out : r_rs);

  // State register; rdy low freezes the sequencer
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else if (rdy) begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state, ALU command and datapath next values
  always_comb begin
    w_state_nxt = r_state;
    w_alu_op    = OP_PASS;
    w_alu_right = 1'b0;
    w_alu_ai    = '0;
    w_alu_bi    = '0;
    w_alu_ci    = 1'b0;
    w_q_nxt     = r_q;
    w_d_nxt     = r_d;
    w_r_nxt     = r_r;
    w_rs_nxt    = r_rs;
    w_c9_nxt    = r_c9;
    w_cnt_nxt   = r_cnt;
    w_first_nxt = r_first;
    w_div_nxt   = r_div;
    w_busy_nxt  = r_busy;
    w_done_nxt  = 1'b0;
    w_err_nxt   = 1'b0;
    w_hi_nxt    = r_hi;
    w_lo_nxt    = r_lo;
    unique case (r_state)
      S_IDLE: begin
        if (start) begin
          w_q_nxt     = a[7:0];
          w_d_nxt     = b;
          w_r_nxt     = a[15:8];
          w_cnt_nxt   = '0;
          w_first_nxt = 1'b1;
          w_div_nxt   = div;
          w_busy_nxt  = 1'b1;
          w_state_nxt = div ? S_DIV_CHK : S_MUL_ADD;
        end
      end
      S_MUL_ADD: begin
        w_alu_ai    = (r_cnt == CW'(0)) ? '0 : alu_out;
        w_alu_bi    = r_d;
        w_alu_op    = r_q[0] ? OP_ADD : OP_PASS;
        w_state_nxt = S_MUL_ROR;
      end
      S_MUL_ROR: begin
        w_alu_ai    = alu_out;
        w_alu_ci    = alu_co;
        w_alu_right = 1'b1;
        w_q_nxt     = {alu_out[0], r_q[DW-1:1]};
        w_cnt_nxt   = r_cnt + CW'(1);
        w_state_nxt = (r_cnt == CW'(7)) ? S_FIN : S_MUL_ADD;
      end
      S_DIV_CHK: begin
        w_alu_ai    = r_r;
        w_alu_bi    = r_d;
        w_alu_op    = OP_SUB;
        w_alu_ci    = 1'b1;
        w_state_nxt = S_DIV_SHL;
      end
      S_DIV_SHL: begin
        if (r_first && alu_co) begin
          // High byte of dividend >= divisor: quotient cannot fit in 8 bits
          w_hi_nxt    = r_r;
          w_lo_nxt    = 8'hFF;
          w_err_nxt   = 1'b1;
          w_done_nxt  = 1'b1;
          w_busy_nxt  = 1'b0;
          w_state_nxt = S_IDLE;
        end else begin
          w_alu_ai    = w_rc;
          w_alu_ci    = r_q[DW-1];
          w_alu_op    = OP_ROL;
          w_q_nxt     = {r_q[DW-2:0], w_qb};
          w_first_nxt = 1'b0;
          w_state_nxt = S_DIV_SUB;
        end
      end
      S_DIV_SUB: begin
        w_rs_nxt    = alu_out;
        w_c9_nxt    = alu_co;
        w_alu_ai    = alu_out;
        w_alu_bi    = r_d;
        w_alu_op    = OP_SUB;
        w_alu_ci    = 1'b1;
        w_cnt_nxt   = r_cnt + CW'(1);
        w_state_nxt = (r_cnt == CW'(7)) ? S_FIN : S_DIV_SHL;
      end
      S_FIN: begin
        if (r_div) begin
          w_hi_nxt = w_rc;
          w_lo_nxt = {r_q[DW-2:0], w_qb};
        end else begin
          w_hi_nxt = alu_out;
          w_lo_nxt = r_q;
        end
        w_done_nxt  = 1'b1;
        w_busy_nxt  = 1'b0;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Datapath and status registers; rdy low holds everything including done
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_q     <= '0;
      r_d     <= '0;
      r_r     <= '0;
      r_rs    <= '0;
      r_c9    <= 1'b0;
      r_cnt   <= '0;
      r_first <= 1'b0;
      r_div   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_hi    <= '0;
      r_lo    <= '0;
    end else if (rdy) begin
      r_q     <= w_q_nxt;
      r_d     <= w_d_nxt;
      r_r     <= w_r_nxt;
      r_rs    <= w_rs_nxt;
      r_c9    <= w_c9_nxt;
      r_cnt   <= w_cnt_nxt;
      r_first <= w_first_nxt;
      r_div   <= w_div_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
      r_err   <= w_err_nxt;
      r_hi    <= w_hi_nxt;
      r_lo    <= w_lo_nxt;
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign err       = r_err;
  assign result_hi = r_hi;
  assign result_lo = r_lo;
  assign alu_op    = w_alu_op;
  assign alu_right = w_alu_right;
  assign alu_ai    = w_alu_ai;
  assign alu_bi    = w_alu_bi;
  assign alu_ci    = w_alu_ci;
  assign alu_bcd   = 1'b0;
  assign alu_rdy   = rdy;

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Directed bench for alu_muldiv_seq with a behavioural registered ALU.
module tb_alu_muldiv_seq;

  logic        clk, reset_n, rdy, start, div;
  logic [15:0] a;
  logic [7:0]  b;
  logic        busy, done, err;
  logic [7:0]  result_hi, result_lo;
  logic [3:0]  alu_op;
  logic        alu_right, alu_ci, alu_bcd, alu_rdy;
  logic [7:0]  alu_ai, alu_bi;
  logic [7:0]  alu_out;
  logic        alu_co;

  int checks = 0;
  int errors = 0;

  alu_muldiv_seq dut (
    .clk(clk), .reset_n(reset_n), .rdy(rdy), .start(start), .div(div),
    .a(a), .b(b), .busy(busy), .done(done), .err(err),
    .result_hi(result_hi), .result_lo(result_lo),
    .alu_op(alu_op), .alu_right(alu_right), .alu_ai(alu_ai), .alu_bi(alu_bi),
    .alu_ci(alu_ci), .alu_bcd(alu_bcd), .alu_rdy(alu_rdy),
    .alu_out(alu_out), .alu_co(alu_co)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Registered 65C02 ALU subset (binary mode only)
  always @(posedge clk or negedge reset_n) begin
    logic [8:0] t;
    if (!reset_n) begin
      alu_out <= 8'h00;
      alu_co  <= 1'b0;
    end else if (alu_rdy) begin
      case (alu_op)
        4'b0011: t = {1'b0, alu_ai} + {1'b0, alu_bi} + {8'h00, alu_ci};
        4'b0111: t = {1'b0, alu_ai} + {1'b0, ~alu_bi} + {8'h00, alu_ci};
        4'b1011: t = {alu_ai, alu_ci};
        default: t = alu_right ? {alu_ai[0], alu_ci, alu_ai[7:1]} : {1'b0, alu_ai};
      endcase
      alu_out <= t[7:0];
      alu_co  <= t[8];
    end
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Launch one operation and check latency, results and the done pulse
  task automatic do_op(input string tag, input logic d, input logic [15:0] av,
                       input logic [7:0] bv, input logic [7:0] exp_hi,
                       input logic [7:0] exp_lo, input logic exp_err,
                       input int exp_lat, input bit tog, input bit hold);
    int lat;
    int n;
    @(negedge clk);
    start = 1'b1; div = d; a = av; b = bv; rdy = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk({tag, " busy@E0"}, 16'(busy), 16'h1);
    chk({tag, " done@E0"}, 16'(done), 16'h0);
    lat = 0;
    n = 0;
    while (done !== 1'b1 && n < 400) begin
      @(negedge clk);
      rdy = tog ? ~rdy : 1'b1;
      @(posedge clk); #1;
      if (rdy) lat++;
      n++;
    end
    chk({tag, " done seen"}, 16'(done), 16'h1);
    chk({tag, " latency"}, 16'(lat), 16'(exp_lat));
    chk({tag, " busy off"}, 16'(busy), 16'h0);
    chk({tag, " err"}, 16'(err), 16'(exp_err));
    chk({tag, " result"}, {result_hi, result_lo}, {exp_hi, exp_lo});
    chk({tag, " alu_rdy"}, 16'(alu_rdy), 16'(rdy));
    if (hold) begin
      @(negedge clk); rdy = 1'b0;
      @(posedge clk); #1;
      chk({tag, " done held"}, 16'(done), 16'h1);
      chk({tag, " alu_rdy low"}, 16'(alu_rdy), 16'h0);
      @(negedge clk); rdy = 1'b1;
      @(posedge clk); #1;
      chk({tag, " done clr"}, 16'(done), 16'h0);
      chk({tag, " err clr"}, 16'(err), 16'h0);
      chk({tag, " result hold"}, {result_hi, result_lo}, {exp_hi, exp_lo});
    end
  endtask

  initial begin
    reset_n = 1'b0; rdy = 1'b1; start = 1'b0; div = 1'b0; a = 16'h0; b = 8'h0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst busy", 16'(busy), 16'h0);
    chk("rst done", 16'(done), 16'h0);
    chk("rst err", 16'(err), 16'h0);
    chk("rst result", {result_hi, result_lo}, 16'h0000);
    chk("rst alu_op", 16'(alu_op), 16'hF);
    chk("rst alu_ops", {alu_ai, alu_bi}, 16'h0000);
    chk("rst alu_bits", {13'h0, alu_right, alu_ci, alu_bcd}, 16'h0);
    @(negedge clk); reset_n = 1'b1;

    do_op("mul ffxff",   1'b0, 16'h00FF, 8'hFF, 8'hFE, 8'h01, 1'b0, 17, 1'b0, 1'b1);
    do_op("mul 0dx0b",   1'b0, 16'h000D, 8'h0B, 8'h00, 8'h8F, 1'b0, 17, 1'b0, 1'b1);
    do_op("mul bx0",     1'b0, 16'hA5A5, 8'h00, 8'h00, 8'h00, 1'b0, 17, 1'b0, 1'b1);
    do_op("div 1234/56", 1'b1, 16'h1234, 8'h56, 8'h10, 8'h36, 1'b0, 18, 1'b0, 1'b1);
    do_op("div feff/ff", 1'b1, 16'hFEFF, 8'hFF, 8'hFE, 8'hFF, 1'b0, 18, 1'b0, 1'b1);
    do_op("div 00ff/01", 1'b1, 16'h00FF, 8'h01, 8'h00, 8'hFF, 1'b0, 18, 1'b0, 1'b1);
    do_op("div ovf",     1'b1, 16'h5600, 8'h56, 8'h56, 8'hFF, 1'b1, 2,  1'b0, 1'b1);
    do_op("div by0",     1'b1, 16'h0012, 8'h00, 8'h00, 8'hFF, 1'b1, 2,  1'b0, 1'b1);
    chk("idle alu_op", 16'(alu_op), 16'hF);
    do_op("mul rdytog",  1'b0, 16'h00FF, 8'hFF, 8'hFE, 8'h01, 1'b0, 17, 1'b1, 1'b1);

    // Reset in the middle of a divide
    @(negedge clk);
    start = 1'b1; div = 1'b1; a = 16'h1234; b = 8'h56; rdy = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("mid busy", 16'(busy), 16'h1);
    reset_n = 1'b0;
    #1;
    chk("abort busy", 16'(busy), 16'h0);
    chk("abort done", 16'(done), 16'h0);
    chk("abort result", {result_hi, result_lo}, 16'h0000);
    chk("abort alu_op", 16'(alu_op), 16'hF);
    @(negedge clk); reset_n = 1'b1;

    // Back-to-back: second start issued while done of the first is high
    do_op("b2b first",   1'b1, 16'h1234, 8'h56, 8'h10, 8'h36, 1'b0, 18, 1'b0, 1'b0);
    do_op("b2b second",  1'b0, 16'h000D, 8'h0B, 8'h00, 8'h8F, 1'b0, 17, 1'b0, 1'b1);

    // start while busy is ignored
    @(negedge clk);
    start = 1'b1; div = 1'b0; a = 16'h0003; b = 8'h05;
    @(posedge clk); #1;
    a = 16'h00FF; b = 8'hFF;
    repeat (20) @(posedge clk);
    #1;
    start = 1'b0;
    chk("busy ign result", {result_hi, result_lo}, 16'h000F);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
